// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed-priority display fetch plus a FIFO-buffered pixel writer.
// Optional `VRAM_WR_VBLANK_ONLY_EN restricts writer grants to vertical blanking.
module vram_arbiter #(
    parameter int FB_W       = 320,
    parameter int FB_H       = 240,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    pixel_x,
    input  logic [9:0]                    pixel_y,
    input  logic                          video_on,
    input  logic                          p_tick,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic                          ram_we,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic [DATA_W-1:0]             pix_data,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_level
);
    localparam int PTR_W   = $clog2(WBUF_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int FB_SIZE = FB_W * FB_H;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {GNT_IDLE, GNT_DISP, GNT_WR} gnt_e;

    gnt_e              gnt_q, gnt_d;
    wr_req_t           fifo_q [WBUF_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              wr_ready_q, wr_ready_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              push, pop, wr_allow, head_ok;
    logic              disp_slot, disp_vis, last_x;
    logic [9:0]        nx, ny;
    logic [ADDR_W-1:0] row, col, disp_addr;
    wr_req_t           head;

`ifdef VRAM_WR_VBLANK_ONLY_EN
    assign wr_allow = (pixel_y >= 10'(2 * FB_H));
`else
    assign wr_allow = 1'b1;
`endif

    // The slot fetches the pair the beam enters next, so coordinates are advanced by one.
    always_comb begin
        last_x    = (pixel_x == 10'd799);
        nx        = last_x ? 10'd0 : pixel_x + 10'd1;
        ny        = last_x ? ((pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1) : pixel_y;
        disp_slot = p_tick && pixel_x[0];
        disp_vis  = (int'(nx) < 2 * FB_W) && (int'(ny) < 2 * FB_H);
        row       = ADDR_W'(ny[9:1]);
        col       = ADDR_W'(nx[9:1]);
        disp_addr = ADDR_W'(row * FB_W + col);
        head      = fifo_q[rptr_q];
        head_ok   = (head.addr < ADDR_W'(FB_SIZE));
    end

    always_comb begin
        gnt_d     = GNT_IDLE;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = head.data;
        pop       = 1'b0;
        if (disp_slot && disp_vis) begin
            gnt_d    = GNT_DISP;
            ram_addr = disp_addr;
        end else if (level_q != '0 && wr_allow) begin
            gnt_d = GNT_WR;
            pop   = 1'b1;
            // Out-of-range heads are consumed without touching the RAM.
            if (head_ok) begin
                ram_we   = 1'b1;
                ram_addr = head.addr;
            end
        end
        addr_d = ram_addr;
    end

    always_comb begin
        push       = wr_valid && wr_ready_q;
        wptr_d     = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d     = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
        wr_ready_d = (level_d < LVL_W'(WBUF_DEPTH));
    end

    // Read data is forwarded in the cycle it arrives and then held for the rest of the pair.
    always_comb begin
        pix_d = pix_q;
        if (gnt_q == GNT_DISP)
            pix_d = ram_rdata;
        else if (disp_slot && !disp_vis)
            pix_d = '0;
        if (!video_on)
            pix_data = '0;
        else if (gnt_q == GNT_DISP)
            pix_data = ram_rdata;
        else
            pix_data = pix_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q      <= GNT_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            wr_ready_q <= 1'b0;
            pix_q      <= '0;
            addr_q     <= '0;
        end else begin
            gnt_q      <= gnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            wr_ready_q <= wr_ready_d;
            pix_q      <= pix_d;
            addr_q     <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wptr_q] <= '{addr: wr_addr, data: wr_data};
    end

    assign wr_ready   = wr_ready_q;
    assign wbuf_level = level_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: scoreboard of accepted writes checked against RAM write cycles,
// plus directed display-fetch, boundary and reset checks.
module tb_vram_arbiter;
    localparam int FB_W    = 320;
    localparam int FB_H    = 240;
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int FB_SIZE = FB_W * FB_H;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wexp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        px, py;
    logic              pt;
    logic              video_on;
    logic              wr_valid, wr_ready;
    logic [ADDR_W-1:0] wr_addr, ram_addr;
    logic [DATA_W-1:0] wr_data, ram_wdata, ram_rdata, pix_data;
    logic              ram_we;
    logic [2:0]        wbuf_level;

    int    n_tests = 0;
    int    n_fail  = 0;
    wexp_t sb[$];
    logic [DATA_W-1:0] mem [0:FB_SIZE-1];

    always #5 clk = ~clk;
    assign video_on = (px < 10'd640) && (py < 10'd480);

    always @(posedge clk) begin
        if (ram_we && ram_addr < FB_SIZE) mem[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_addr < FB_SIZE) ? mem[ram_addr] : 8'h00;
    end

    vram_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                   .WBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pixel_x(px), .pixel_y(py), .video_on(video_on),
        .p_tick(pt), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .pix_data(pix_data), .wbuf_level(wbuf_level)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Checks the cycle as it stands, takes one clock edge, then advances the sync model.
    task automatic step();
        int nx, ny;
        wexp_t e;
        if (ram_we) begin
            if (sb.size() == 0) chk("we_unexpected", 32'(ram_we), 32'd0);
            else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(e.a));
                chk("wr_data", 32'(ram_wdata), 32'(e.d));
            end
        end
        if (pt && px[0]) begin
            nx = int'(px) + 1; ny = int'(py);
            if (px == 10'd799) begin nx = 0; ny = (py == 10'd524) ? 0 : int'(py) + 1; end
            if (nx < 640 && ny < 480) begin
                chk("slot_we", 32'(ram_we), 32'd0);
                chk("slot_addr", 32'(ram_addr), 32'((ny / 2) * FB_W + nx / 2));
            end
        end
        if (wr_valid && wr_ready && !reset && wr_addr < FB_SIZE)
            sb.push_back('{a: wr_addr, d: wr_data});
        @(posedge clk);
        #1;
        if (pt) begin
            if (px == 10'd799) begin
                px = 10'd0;
                py = (py == 10'd524) ? 10'd0 : py + 10'd1;
            end else px = px + 10'd1;
        end
        pt = ~pt;
        #1;
    endtask

    task automatic goto(input int x, input int y);
        px = 10'(x); py = 10'(y); pt = 1'b0;
        #1;
    endtask

    task automatic drain(input int n);
        wr_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr1(input int a, input int d);
        logic acc;
        acc = 1'b0;
        wr_valid = 1'b1; wr_addr = ADDR_W'(a); wr_data = DATA_W'(d);
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = wr_ready;
            step();
        end
        if (!acc) chk("wr_accept_timeout", 32'(acc), 32'd1);
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic acc;
        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        px = 10'd0; py = 10'd490; pt = 1'b0;
        #2;
        chk("rst_ready", 32'(wr_ready), 32'd0);
        chk("rst_level", 32'(wbuf_level), 32'd0);
        chk("rst_pix", 32'(pix_data), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        step(); step();
        reset = 1'b0;
        chk("ready_pre", 32'(wr_ready), 32'd0);
        step();
        chk("ready_rise", 32'(wr_ready), 32'd1);

        // preload through the writer during blanking
        wr1(0, 8'hA5); wr1(1, 8'h3C); wr1(1919, 8'h77);
        drain(4);
        chk("preload_drained", 32'(sb.size()), 32'd0);
        chk("preload_level", 32'(wbuf_level), 32'd0);

        // end-of-frame slot fetches address 0 for line 0
        goto(799, 524);
        step();
        chk("wrap_addr", 32'(ram_addr), 32'd0);
        chk("wrap_we", 32'(ram_we), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("line0_pix", 32'(pix_data), (i < 4) ? 32'hA5 : 32'h3C);
        end

        // right edge: last visible pair, then an idle slot
        goto(637, 10);
        step();
        step();
        chk("edge_pix0", 32'(pix_data), 32'h77);
        step(); step();
        chk("edge_pix1", 32'(pix_data), 32'h77);
        step();
        chk("edge_we", 32'(ram_we), 32'd0);
        chk("edge_hold", 32'(ram_addr), 32'd1919);
        step();
        chk("edge_blank", 32'(pix_data), 32'd0);

        // out-of-range write is consumed without a RAM write
        goto(0, 490);
        wr_valid = 1'b1; wr_addr = ADDR_W'(FB_SIZE); wr_data = 8'h55;
        step();
        wr_valid = 1'b0;
        chk("oor_level1", 32'(wbuf_level), 32'd1);
        chk("oor_we", 32'(ram_we), 32'd0);
        step();
        chk("oor_level0", 32'(wbuf_level), 32'd0);

`ifdef VRAM_WR_VBLANK_ONLY_EN
        goto(0, 20);
        wr_valid = 1'b1; wr_addr = ADDR_W'(5); wr_data = 8'h11;
        for (int i = 0; i < 6; i++) step();
        wr_valid = 1'b0;
        chk("vb_ready", 32'(wr_ready), 32'd0);
        chk("vb_level", 32'(wbuf_level), 32'd4);
        goto(0, 490);
        drain(8);
        chk("vb_drained", 32'(sb.size()), 32'd0);
`endif

        // continuous writes across an active line
        goto(0, 20);
        acc = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (acc) begin
                wr_addr = ADDR_W'($urandom_range(0, FB_SIZE - 1));
                wr_data = DATA_W'($urandom_range(0, 255));
            end
            acc = wr_ready;
            step();
        end
        wr_valid = 1'b0;
        goto(0, 490);
        drain(8);
        chk("stream_no_loss", 32'(sb.size()), 32'd0);
        chk("stream_level", 32'(wbuf_level), 32'd0);

        // reset in the middle of a frame with writes still queued
        goto(0, 30);
        wr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wr_addr = ADDR_W'(100 + i); wr_data = DATA_W'(i);
            step();
        end
        #1;
        reset = 1'b1;
        #1;
        wr_valid = 1'b0;
        sb.delete();
        chk("mid_level", 32'(wbuf_level), 32'd0);
        chk("mid_ready", 32'(wr_ready), 32'd0);
        chk("mid_we", 32'(ram_we), 32'd0);
        step(); step();
        reset = 1'b0;
        step();
        chk("mid_ready_rise", 32'(wr_ready), 32'd1);
        drain(6);
        chk("mid_level_after", 32'(wbuf_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
